// File: rtl/b01_sched_pkg.sv
// Shared types for the b01 stream scheduler: scheduler FSM states and
// the b01 comparator state encodings used by reference models.
package b01_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      SHIFT,
      DRAIN,
      RESP
   } sched_state_t;

   typedef enum logic [2:0] {
      B01_A   = 3'b000,
      B01_B   = 3'b001,
      B01_C   = 3'b010,
      B01_E   = 3'b011,
      B01_F   = 3'b100,
      B01_G   = 3'b101,
      B01_WF0 = 3'b110,
      B01_WF1 = 3'b111
   } b01_state_t;

endpackage

// File: rtl/b01_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins outright, a tie
// goes to the requester that did not win last time.
module b01_rr_arb2 (
   input  logic [1:0] req_valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = req_valid;
      if (&req_valid)
         grant = last_grant ? 2'b01 : 2'b10;
   end

endmodule

// File: rtl/b01_stream_sched.sv
// Shares one b01 serial comparator between two requesters: serialises
// A/B LSB first, deserialises outp and counts overflw pulses per job.
module b01_stream_sched
   import b01_sched_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_outp,
   output logic [CNT_W-1:0]  rsp_ovf_cnt,
   output logic              busy,
   output logic              cmp_reset,
   output logic              cmp_line1,
   output logic              cmp_line2,
   input  logic              cmp_outp,
   input  logic              cmp_overflw
);

   localparam int K_W = $clog2(DATA_W);
   localparam logic [K_W-1:0] K_LAST = K_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   sched_state_t      state;
   logic [K_W-1:0]    k;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic              last_grant;
   logic [1:0]        grant;
   logic              grant_id;

   b01_rr_arb2 u_arb (
      .req_valid (req_valid),
      .last_grant(last_grant),
      .grant     (grant)
   );

   assign grant_id  = grant[1];
   assign req_ready = (state == IDLE) ? grant : 2'b00;
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);
   assign cmp_reset = ~reset_n | (state == CLR);
   assign cmp_line1 = (state == SHIFT) & a_q[0];
   assign cmp_line2 = (state == SHIFT) & b_q[0];

   function automatic logic [CNT_W-1:0] sat_add(
      input logic [CNT_W-1:0] c,
      input logic             inc
   );
      if (c == CNT_MAX)
         return c;
      return c + CNT_W'(inc);
   endfunction

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         k           <= '0;
         a_q         <= '0;
         b_q         <= '0;
         last_grant  <= 1'b1;
         rsp_id      <= 1'b0;
         rsp_outp    <= '0;
         rsp_ovf_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (grant != 2'b00) begin
                  a_q         <= grant_id ? req1_a : req0_a;
                  b_q         <= grant_id ? req1_b : req0_b;
                  rsp_id      <= grant_id;
                  last_grant  <= grant_id;
                  rsp_outp    <= '0;
                  rsp_ovf_cnt <= '0;
                  state       <= CLR;
               end
            end
            CLR: begin
               k     <= '0;
               state <= SHIFT;
            end
            SHIFT: begin
               a_q <= a_q >> 1;
               b_q <= b_q >> 1;
               k   <= k + K_W'(1);
               // k==0 sees the comparator's cleared state, not a result
               if (k != '0) begin
                  rsp_outp    <= {cmp_outp, rsp_outp[DATA_W-1:1]};
                  rsp_ovf_cnt <= sat_add(rsp_ovf_cnt, cmp_overflw);
               end
               if (k == K_LAST)
                  state <= DRAIN;
            end
            DRAIN: begin
               rsp_outp    <= {cmp_outp, rsp_outp[DATA_W-1:1]};
               rsp_ovf_cnt <= sat_add(rsp_ovf_cnt, cmp_overflw);
               state       <= RESP;
            end
            RESP: begin
               if (rsp_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_b01_stream_sched.sv
// Self-checking bench for b01_stream_sched with a behavioural b01
// comparator attached and a per-job reference model.
module tb_b01_stream_sched;
   import b01_sched_pkg::*;

   localparam int DW   = 8;
   localparam int CW   = 4;
   localparam int CW_S = 3;
   localparam int MAX  = (1 << CW) - 1;
   localparam int MAXS = (1 << CW_S) - 1;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          reset_n;
   logic [1:0]    req_valid;
   logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
   logic          rsp_ready;
   logic          force_ovf;

   logic [1:0]    req_ready;
   logic          rsp_valid, rsp_id, busy;
   logic [DW-1:0] rsp_outp;
   logic [CW-1:0] rsp_ovf_cnt;
   logic          cmp_reset, cmp_line1, cmp_line2, cmp_outp, cmp_overflw;

   logic [1:0]      s_req_ready;
   logic            s_rsp_valid, s_rsp_id, s_busy;
   logic [DW-1:0]   s_rsp_outp;
   logic [CW_S-1:0] s_ovf_cnt;
   logic            s_cmp_reset, s_cmp_line1, s_cmp_line2;

   logic [2:0] m_s;
   logic       m_o, m_v;
   logic       last_g;
   int         total, bad;

   b01_stream_sched #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_outp(rsp_outp), .rsp_ovf_cnt(rsp_ovf_cnt), .busy(busy),
      .cmp_reset(cmp_reset), .cmp_line1(cmp_line1), .cmp_line2(cmp_line2),
      .cmp_outp(cmp_outp), .cmp_overflw(cmp_overflw)
   );

   // Narrow-counter twin shares all stimulus; it only differs in saturation.
   b01_stream_sched #(.DATA_W(DW), .CNT_W(CW_S)) dut_s (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(s_req_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id),
      .rsp_outp(s_rsp_outp), .rsp_ovf_cnt(s_ovf_cnt), .busy(s_busy),
      .cmp_reset(s_cmp_reset), .cmp_line1(s_cmp_line1), .cmp_line2(s_cmp_line2),
      .cmp_outp(cmp_outp), .cmp_overflw(cmp_overflw)
   );

   function automatic logic [4:0] b01_step(
      input logic [2:0] s, input logic l1, input logic l2
   );
      logic [2:0] ns;
      logic x, o, v;
      x = l1 ^ l2; o = x; v = 1'b0; ns = B01_A;
      case (s)
         B01_A:   ns = (l1 & l2) ? B01_F : B01_B;
         B01_E:   begin ns = (l1 & l2) ? B01_F : B01_B; v = 1'b1; end
         B01_B:   ns = (l1 & l2) ? B01_G : B01_C;
         B01_F:   begin ns = (l1 | l2) ? B01_G : B01_C; o = ~x; end
         B01_C:   ns = (l1 & l2) ? B01_WF1 : B01_WF0;
         B01_G:   begin ns = (l1 | l2) ? B01_WF1 : B01_WF0; o = ~x; end
         B01_WF0: ns = (l1 & l2) ? B01_E : B01_A;
         default: begin ns = (l1 | l2) ? B01_E : B01_A; o = ~x; end
      endcase
      return {ns, o, v};
   endfunction

   always @(posedge clock) begin
      if (cmp_reset) begin
         m_s <= B01_A; m_o <= 1'b0; m_v <= 1'b0;
      end else begin
         {m_s, m_o, m_v} <= b01_step(m_s, cmp_line1, cmp_line2);
      end
   end

   assign cmp_outp    = m_o;
   assign cmp_overflw = m_v | force_ovf;

   // Expected job result: outp bit i answers bit-pair i from a fresh b01.
   task automatic ref_job(
      input logic [DW-1:0] a, input logic [DW-1:0] b,
      output logic [DW-1:0] o, output int c
   );
      logic [2:0] s;
      logic [4:0] r;
      s = B01_A; o = '0; c = 0;
      for (int i = 0; i < DW; i++) begin
         r = b01_step(s, a[i], b[i]);
         s = r[4:2];
         o[i] = r[1];
         c += force_ovf ? 1 : int'(r[0]);
      end
   endtask

   task automatic do_job(
      input logic id, input logic [DW-1:0] a, input logic [DW-1:0] b,
      input int hold, input logic pend, input string tag
   );
      logic [DW-1:0] eo;
      logic [1:0] oh;
      int ec, n;
      ref_job(a, b, eo, ec);
      oh = id ? 2'b10 : 2'b01;
      if (id) begin req1_a = a; req1_b = b; end
      else begin req0_a = a; req0_b = b; end
      req_valid = oh;
      #1;
      n = 0;
      while (req_ready === 2'b00 && n < 40) begin
         @(negedge clock); #1; n++;
      end
      total++;
      if (req_ready !== oh) begin
         bad++; $display("FAIL %s grant: got %b want %b", tag, req_ready, oh);
      end
      last_g = id;
      n = 0;
      do begin
         @(negedge clock); #1; n++;
         if (n == 1) req_valid = 2'b00;
      end while (rsp_valid !== 1'b1 && n < 40);
      total++;
      if (n != DW + 3) begin
         bad++; $display("FAIL %s latency: got %0d want %0d", tag, n, DW + 3);
      end
      total++;
      if (rsp_id !== id) begin
         bad++; $display("FAIL %s id: got %b want %b", tag, rsp_id, id);
      end
      total++;
      if (rsp_outp !== eo) begin
         bad++; $display("FAIL %s outp: got %h want %h", tag, rsp_outp, eo);
      end
      total++;
      if (rsp_ovf_cnt !== CW'(ec > MAX ? MAX : ec)) begin
         bad++; $display("FAIL %s ovf: got %0d want %0d", tag, rsp_ovf_cnt, ec);
      end
      total++;
      if (s_ovf_cnt !== CW_S'(ec > MAXS ? MAXS : ec)) begin
         bad++; $display("FAIL %s ovf_sat: got %0d want %0d", tag, s_ovf_cnt,
                         ec > MAXS ? MAXS : ec);
      end
      if (pend) req_valid = 2'b10;
      for (int h = 0; h < hold; h++) begin
         @(negedge clock); #1;
         total++;
         if (rsp_valid !== 1'b1 || rsp_outp !== eo || rsp_id !== id ||
             rsp_ovf_cnt !== CW'(ec > MAX ? MAX : ec) || req_ready !== 2'b00) begin
            bad++; $display("FAIL %s hold%0d: valid=%b outp=%h ready=%b want 1 %h 00",
                            tag, h, rsp_valid, rsp_outp, req_ready, eo);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clock); #1;
      rsp_ready = 1'b0;
      total++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL %s done: valid=%b busy=%b want 0 0", tag, rsp_valid, busy);
      end
      if (pend) begin
         total++;
         if (req_ready !== 2'b10) begin
            bad++; $display("FAIL %s regrant: got %b want 10", tag, req_ready);
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0; force_ovf = 1'b0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; last_g = 1'b1;
      repeat (3) @(negedge clock);
      #1;
      total++;
      if ({rsp_valid, busy, req_ready, rsp_id} !== 5'b0) begin
         bad++; $display("FAIL reset ctl: got %b want 00000",
                         {rsp_valid, busy, req_ready, rsp_id});
      end
      total++;
      if (rsp_outp !== '0 || rsp_ovf_cnt !== '0) begin
         bad++; $display("FAIL reset data: got %h/%0d want 0/0", rsp_outp, rsp_ovf_cnt);
      end
      total++;
      if ({cmp_reset, cmp_line1, cmp_line2} !== 3'b100) begin
         bad++; $display("FAIL reset cmp: got %b want 100",
                         {cmp_reset, cmp_line1, cmp_line2});
      end
      reset_n = 1'b1;
      #1;
      total++;
      if (cmp_reset !== 1'b0) begin
         bad++; $display("FAIL reset release: cmp_reset=%b want 0", cmp_reset);
      end
   endtask

   task automatic test_abort();
      int n, viol;
      req1_a = '1; req1_b = '1; req_valid = 2'b10;
      #1;
      n = 0;
      while (req_ready === 2'b00 && n < 40) begin
         @(negedge clock); #1; n++;
      end
      total++;
      if (req_ready !== 2'b10) begin
         bad++; $display("FAIL abort grant: got %b want 10", req_ready);
      end
      @(negedge clock); #1;
      req_valid = 2'b00;
      repeat (4) @(negedge clock);
      total++;
      if ({cmp_line1, cmp_line2, busy} !== 3'b111) begin
         bad++; $display("FAIL abort midshift: got %b want 111",
                         {cmp_line1, cmp_line2, busy});
      end
      reset_n = 1'b0;
      #1;
      total++;
      if ({rsp_valid, busy, req_ready, rsp_id, cmp_line1, cmp_line2} !== 7'b0 ||
          rsp_outp !== '0 || rsp_ovf_cnt !== '0 || cmp_reset !== 1'b1) begin
         bad++; $display("FAIL abort reset: ctl=%b outp=%h cnt=%0d cmp_reset=%b",
                         {rsp_valid, busy, req_ready, rsp_id, cmp_line1, cmp_line2},
                         rsp_outp, rsp_ovf_cnt, cmp_reset);
      end
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      last_g = 1'b1;
      viol = 0;
      repeat (20) begin
         @(negedge clock); #1;
         if (rsp_valid !== 1'b0 || busy !== 1'b0) viol++;
      end
      total++;
      if (viol != 0) begin
         bad++; $display("FAIL abort norsp: got %0d busy cycles want 0", viol);
      end
   endtask

   task automatic test_rr();
      logic [DW-1:0] a [2];
      logic [DW-1:0] b [2];
      logic [DW-1:0] eo;
      logic g;
      int ec, n, pulses;
      for (int i = 0; i < 2; i++) begin
         a[i] = DW'($urandom); b[i] = DW'($urandom);
      end
      req0_a = a[0]; req0_b = b[0]; req1_a = a[1]; req1_b = b[1];
      req_valid = 2'b11; rsp_ready = 1'b1;
      #1;
      for (int j = 0; j < 4; j++) begin
         g = ~last_g;
         n = 0;
         while (req_ready === 2'b00 && n < 40) begin
            @(negedge clock); #1; n++;
         end
         total++;
         if (req_ready !== (g ? 2'b10 : 2'b01)) begin
            bad++; $display("FAIL rr%0d grant: got %b want id %b", j, req_ready, g);
         end
         ref_job(a[g], b[g], eo, ec);
         last_g = g;
         @(negedge clock); #1;
         a[g] = DW'($urandom); b[g] = DW'($urandom);
         if (g) begin req1_a = a[1]; req1_b = b[1]; end
         else begin req0_a = a[0]; req0_b = b[0]; end
         if (j == 3) req_valid = 2'b00;
         pulses = 0; n = 0;
         while (rsp_valid !== 1'b1 && n < 40) begin
            if (req_ready !== 2'b00) pulses++;
            @(negedge clock); #1; n++;
         end
         total++;
         if (pulses != 0) begin
            bad++; $display("FAIL rr%0d pulses: got %0d extra want 0", j, pulses);
         end
         total++;
         if (rsp_id !== g || rsp_outp !== eo || rsp_ovf_cnt !== CW'(ec)) begin
            bad++; $display("FAIL rr%0d rsp: got %b/%h/%0d want %b/%h/%0d",
                            j, rsp_id, rsp_outp, rsp_ovf_cnt, g, eo, ec);
         end
         @(negedge clock); #1;
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] pa, pb;
      pa = DW'($urandom); pb = DW'($urandom);
      req1_a = pa; req1_b = pb;
      do_job(1'b0, DW'($urandom), DW'($urandom), 5, 1'b1, "bp");
      do_job(1'b1, pa, pb, 0, 1'b0, "bp_next");
   endtask

   task automatic test_sat();
      force_ovf = 1'b1;
      do_job(1'b0, DW'($urandom), DW'($urandom), 0, 1'b0, "sat0");
      do_job(1'b1, DW'($urandom), DW'($urandom), 1, 1'b0, "sat1");
      force_ovf = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 16; i++)
         do_job(1'($urandom), DW'($urandom), DW'($urandom),
                $urandom_range(0, 3), 1'b0, "rand");
   endtask

   initial begin
      total = 0; bad = 0;
      test_reset();
      do_job(1'b0, 8'h00, 8'h00, 0, 1'b0, "zero");
      do_job(1'b0, 8'hFF, 8'hFF, 0, 1'b0, "ones");
      test_abort();
      test_rr();
      test_backpressure();
      test_sat();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
